seq_mult_unit: RTL and testbench

- Parametrised sequential shift-add multiplier; successor to the registered single-cycle multiplier.
- Trades area for latency: one partial product per clock, N iterations.
- Adds a start/busy/done handshake, run-time signed/unsigned mode and an N-bit overflow flag.
- Sits between register-file operand fetch and the writeback stage of the arithmetic datapath.

---
 rtl/seq_mult_unit.sv | 96 +++++++++
 tb/tb_seq_mult_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: shift-add multiplier, one partial product per clock; SEQ_MULT_EARLY_TERM_EN enables early exit
module seq_mult_unit #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   inputA,
  input  logic [N-1:0]   inputB,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           overflow
);
  localparam int CNT_W = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d, result_q, result_d, prod;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           neg_q, neg_d, mode_q, mode_d, done_q, done_d, ovf_q, ovf_d, last;
  assign busy     = state_q == RUN;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign prod     = neg_q ? -acc_q : acc_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last = (mplier_q >> 1) == '0 || cnt_q == CNT_W'(N - 1);
`else
  assign last = cnt_q == CNT_W'(N - 1);
`endif
  // next-state: accept in IDLE, iterate in RUN, sign-fix and flag overflow when leaving DONE
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d   = signed_mode;
        neg_d    = signed_mode & (inputA[N-1] ^ inputB[N-1]);
        mcand_d  = (signed_mode && inputA[N-1]) ? -inputA : inputA;
        mplier_d = (signed_mode && inputB[N-1]) ? -inputB : inputB;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        acc_d    = mplier_q[0] ? acc_q + ({{N{1'b0}}, mcand_q} << cnt_q) : acc_q;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = last ? DONE : RUN;
      end
      DONE: begin
        result_d = prod;
        ovf_d    = mode_q ? ~(&prod[2*N-1:N-1] | ~|prod[2*N-1:N-1]) : |prod[2*N-1:N];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset clears everything and aborts any run
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: directed checks of seq_mult_unit at N=8
module tb_seq_mult_unit;
  logic        clk, reset, start, signed_mode, busy, done, overflow;
  logic [7:0]  inputA, inputB;
  logic [15:0] result;
  logic [15:0] last_res;
  logic        last_ovf;
  int vectors, miscompares;
  seq_mult_unit #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .inputA(inputA), .inputB(inputB), .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // inj: cycle index (edges after start) at which to pulse a stray start; -1 none, -2 the DONE cycle
  task automatic run_op(input string tag, input bit sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input bit eo, input int early_lat, input int inj);
    int lat, inj_e, edges, busy_cnt;
    bit stable;
`ifdef SEQ_MULT_EARLY_TERM_EN
    lat = early_lat;
`else
    lat = 9;
`endif
    inj_e = (inj == -2) ? lat - 1 : inj;
    signed_mode = sm;
    inputA = a;
    inputB = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    signed_mode = ~sm;
    inputA = ~a;
    inputB = ~b;
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    stable = 1'b1;
    while (!done && edges < 30) begin
      if (edges == inj_e) begin
        start = 1'b1;
        inputA = 8'h5A;
        inputB = 8'hC3;
      end
      if (result !== last_res || overflow !== last_ovf) stable = 1'b0;
      tick();
      edges++;
      start = 1'b0;
      if (!done && busy) busy_cnt++;
    end
    chk({tag, " latency"}, edges, lat);
    chk({tag, " busy_cycles"}, busy_cnt, lat - 1);
    chk({tag, " held_prev"}, {31'd0, stable}, 32'd1);
    chk({tag, " result"}, {16'd0, result}, {16'd0, er});
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
    tick();
    chk({tag, " done_after"}, {30'd0, done, busy}, 32'd0);
    last_res = er;
    last_ovf = eo;
  endtask
  initial begin
    bit saw_done;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b1;
    signed_mode = 1'b0;
    inputA = 8'd3;
    inputB = 8'd3;
    tick();
    tick();
    chk("reset_state", {busy, done, overflow, 13'd0, result}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);
    last_res = 16'h0000;
    last_ovf = 1'b0;
    run_op("u12x10",   1'b0, 8'd12,  8'd10,  16'h0078, 1'b0, 5, -1);
    run_op("u255x255", 1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b1, 9, -1);
    run_op("s-3x5",    1'b1, 8'hFD,  8'h05,  16'hFFF1, 1'b0, 4, -1);
    run_op("s-128sq",  1'b1, 8'h80,  8'h80,  16'h4000, 1'b1, 9, -1);
    run_op("u16x15",   1'b0, 8'h10,  8'h0F,  16'h00F0, 1'b0, 5, -1);
    run_op("s16x15",   1'b1, 8'h10,  8'h0F,  16'h00F0, 1'b1, 5, -1);
    run_op("s100x-2",  1'b1, 8'd100, 8'hFE,  16'hFF38, 1'b1, 3, -1);
    run_op("s0x-5",    1'b1, 8'h00,  8'hFB,  16'h0000, 1'b0, 4, -1);
    run_op("u7x9_inj", 1'b0, 8'd7,   8'd9,   16'h003F, 1'b0, 5, 2);
    run_op("u12x10_dn",1'b0, 8'd12,  8'd10,  16'h0078, 1'b0, 5, -2);
    run_op("u200x1",   1'b0, 8'd200, 8'd1,   16'h00C8, 1'b0, 2, -1);
    run_op("u200x0",   1'b0, 8'd200, 8'd0,   16'h0000, 1'b0, 2, -1);
    signed_mode = 1'b0;
    inputA = 8'hFF;
    inputB = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", {busy, done, overflow, 13'd0, result}, 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    last_res = 16'h0000;
    last_ovf = 1'b0;
    run_op("post_abort", 1'b0, 8'd12, 8'd10, 16'h0078, 1'b0, 5, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
